// File: rtl/pe_result_drain.sv
// Captures a DEPTH-row burst of per-lane accumulator results and drains it lane by lane, pulsing rd_eop per lane.
// Latency: first word valid the cycle after the last capture beat; one word per cycle while out_ready is high.
// Backpressure: out_ready low stalls the drain with out_data/out_lane/out_last held; no out_ready-to-output path.
// Optional: define RESULT_SAT_EN to saturate DW->OW on output instead of truncating.
module pe_result_drain #(
  parameter int LANES = 8,
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int OW    = 16,
  localparam int LW   = $clog2(LANES),
  localparam int RW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_sop,
  input  logic                  psum_vld,
  input  logic [LANES*DW-1:0]   psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic [LW-1:0]         out_lane,
  output logic                  out_last,
  output logic [LANES-1:0]      rd_eop,
  output logic                  busy,
  output logic                  sop_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [RW-1:0] R_LAST = RW'(DEPTH - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LANES - 1);

`ifdef RESULT_SAT_EN
  localparam logic [DW-1:0] SAT_HI = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_LO = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  state_t          state;
  logic [RW-1:0]   r;
  logic [LW-1:0]   l;
  logic [RW-1:0]   w;
  logic [DW-1:0]   mem [LANES][DEPTH];

  // Accumulator-to-output word conversion.
  function automatic logic [OW-1:0] conv(input logic [DW-1:0] x);
`ifdef RESULT_SAT_EN
    if ($signed(x) > $signed(SAT_HI))
      conv = {1'b0, {(OW-1){1'b1}}};
    else if ($signed(x) < $signed(SAT_LO))
      conv = {1'b1, {(OW-1){1'b0}}};
    else
      conv = x[OW-1:0];
`else
    // Plain truncation; the zero mask only keeps the dropped upper bits referenced.
    conv = x[OW-1:0] | ({OW{1'b0}} & OW'(x[DW-1:OW]));
`endif
  endfunction

  // Result buffer: one row of all lanes per accepted capture beat (not reset).
  always_ff @(posedge clk) begin
    if (!rst && state == CAPT && psum_vld) begin
      for (int i = 0; i < LANES; i++) begin
        mem[i][r] <= psum_in[i*DW +: DW];
      end
    end
  end

  // Control FSM with registered valid/busy/eop/error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      l         <= '0;
      w         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rd_eop    <= '0;
      sop_err   <= 1'b0;
    end else begin
      rd_eop <= '0;
      if (save_sop && state != IDLE) begin
        sop_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (save_sop) begin
            r     <= '0;
            l     <= '0;
            w     <= '0;
            busy  <= 1'b1;
            state <= CAPT;
          end
        end
        CAPT: begin
          if (psum_vld) begin
            if (r == R_LAST) begin
              r         <= '0;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end else begin
              r <= r + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (w == R_LAST) begin
              w         <= '0;
              rd_eop[l] <= 1'b1;
              if (l == L_LAST) begin
                out_valid <= 1'b0;
                state     <= DONE;
              end else begin
                l <= l + 1'b1;
              end
            end else begin
              w <= w + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drain word muxed from the buffer and index registers; zero outside DRAIN.
  always_comb begin
    out_data = '0;
    out_lane = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = conv(mem[l][w]);
      out_lane = l;
      out_last = (w == R_LAST);
    end
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Result-side responder for the NPU controller's save handshake. On `save_sop` it captures a DEPTH-row burst of per-lane accumulator results from the PE array and buffers it. It then streams the buffer lane by lane over a valid/ready port toward the AXI side. When each lane's last word is accepted, it pulses that lane's `rd_eop` bit, and the controller ORs these bits into its completion mask.

## Interface
- `LANES`, 8: number of PE lanes; also the width of `rd_eop`.
- `DEPTH`, 4: result words per lane per save (≥2).
- `DW`, 32: accumulator width, signed.
- `OW`, 16: output word width, signed (`OW` < `DW`).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `save_sop`  in  1  one-cycle start pulse from the controller.
- `psum_vld`  in  1  capture beat valid; one row of all lanes.
- `psum_in`  in  LANES*DW  row data; lane i = bits [i*DW +: DW].
- `out_valid`  out  1  drain word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  OW  converted result word.
- `out_lane`  out  $clog2(LANES)  lane index of `out_data`.
- `out_last`  out  1  high with the last word of each lane.
- `rd_eop`  out  LANES  per-lane done pulse to the controller.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sop_err`  out  1  sticky: `save_sop` arrived while not IDLE.

## Operation
- Storage is `buf[LANES][DEPTH]` of `DW` bits. Row counter `r` is 0..DEPTH-1. Drain indices are `l` (0..LANES-1) and `w` (0..DEPTH-1).
- States:
  - **IDLE:** waits for `save_sop`. On `save_sop`, clear `r`, `l`, `w` and go to CAPT.
  - **CAPT:** each cycle with `psum_vld`=1, write `buf[i][r]` = lane i of `psum_in` for all i, then `r`++. The beat with `r`=DEPTH-1 moves the state to DRAIN.
  - **DRAIN:** `out_valid`=1. `out_data` = conv(`buf[l][w]`), `out_lane`=`l`, `out_last`=(`w`==DEPTH-1). A handshake (`out_valid` & `out_ready`) advances `w`. When `w`==DEPTH-1, `w` wraps to 0 and `l`++. The handshake with `l`=LANES-1 and `w`=DEPTH-1 moves the state to DONE.
  - **DONE:** stays one cycle, then goes to IDLE.
- `rd_eop[l]` is a registered pulse: high for exactly one cycle, the cycle after the handshake of lane `l`'s last word. All other bits are 0. Over one save, each bit pulses exactly once, in order 0..LANES-1.
- `out_data`, `out_lane` and `out_last` are muxed from registers only. There is no combinational path from `out_ready` to any output.
- `out_data`/`out_lane`/`out_last` hold steady while `out_valid`=1 and `out_ready`=0.

Boundary conditions:
- `psum_vld` outside CAPT is ignored.
- `save_sop` outside IDLE is ignored and sets `sop_err`. `sop_err` is cleared only by `rst`.
- `save_sop` in the same cycle as the DONE→IDLE transition is ignored, because the state is DONE in that cycle.
- `rst` mid-operation: the next state is IDLE and any partial burst is discarded.

## Timing
- Reset values:
  - state IDLE
  - `r`, `l`, `w` = 0
  - `out_valid`, `out_last`, `busy`, `sop_err` = 0
  - `out_data`, `out_lane` = 0
  - `rd_eop` = 0
  - `buf` is not reset.
- `save_sop` at cycle t means CAPT from t+1. The earliest accepted beat is at t+1.
- The last capture beat at cycle c means `out_valid`=1 from c+1.
- With `out_ready` held at 1, the drain takes LANES*DEPTH cycles, i.e. 32 at defaults.
- `rd_eop[LANES-1]` pulses in the DONE cycle, and `busy` falls the cycle after it.
- Minimum save-to-idle time is 1 + DEPTH + LANES*DEPTH + 1 cycles.

## Configuration
- `RESULT_SAT_EN` defined: conv(x) saturates signed `DW` to signed `OW`.
  - x > 2^(OW-1)-1 gives the maximum positive value.
  - x < -2^(OW-1) gives the minimum negative value.
  - Otherwise the result is x[OW-1:0].
- `RESULT_SAT_EN` undefined: conv(x) = x[OW-1:0], plain truncation with no saturation logic.

## Test plan
- **Basic save:** `save_sop`, then 4 beats with lane i row r = 100*i+r, `out_ready`=1.
  - Expect 32 words in order 0,1,2,3,100,…,703.
  - Expect `out_last` on words 3,103,…,703.
  - Expect `rd_eop` = 8'h01, 8'h02, …, 8'h80, each a single-cycle pulse.
- **Backpressure:** toggle `out_ready` 1/0 every cycle.
  - Expect the same 32 words, with `out_data` stable during every stall.
  - Expect 64 DRAIN cycles in total.
- **Saturation:** send lane 0 row 0 = 32'h0001_2345 and lane 1 row 0 = 32'hFFFE_0000.
  - With `RESULT_SAT_EN`: 16'h7FFF and 16'h8000.
  - Without it: 16'h2345 and 16'h0000.
- **Gapped capture:** `psum_vld` is high only on alternate cycles.
  - Expect DRAIN to start the cycle after the 4th beat.
  - Expect words before the 4th beat to be absent.
- **Protocol error:** `save_sop` is pulsed during CAPT and again during DRAIN.
  - Expect `sop_err`=1 and sticky.
  - Expect the stream to be unaffected, with exactly 8 `rd_eop` pulses.
- **Reset mid-drain:** assert `rst` after 10 words.
  - Expect `out_valid`=0, `busy`=0 and `rd_eop`=0 on the next cycle.
  - A fresh save then returns full data from row 0 of lane 0.
